// File: rtl/lightsaber_pkg.sv
// Shared types and default constants for the lightsaber blade sequencer.
package lightsaber_pkg;

    typedef enum logic [2:0] {
        S_OFF        = 3'd0,
        S_IGNITING   = 3'd1,
        S_ON         = 3'd2,
        S_RETRACTING = 3'd3
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int unsigned RAMP_DIV_DEF   = 4;
    localparam int unsigned STEP_DEF       = 4;
    localparam int unsigned LOW_THRESH_DEF = 8;

    localparam logic [1:0] PWR_OFF  = 2'd0;
    localparam logic [1:0] PWR_HOLD = 2'd1;
    localparam logic [1:0] PWR_RAMP = 2'd2;

endpackage

// File: rtl/lightsaber_sequencer_if.sv
// Request/target/power inputs and blade outputs of the sequencer.
interface lightsaber_sequencer_if;

    logic       on_req;
    logic [1:0] tgt_in;
    logic [5:0] tgt_dec;
    logic [7:0] power_level;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic [1:0] len_in;
    logic [5:0] len_dec;
    logic [7:0] r_out;
    logic [7:0] g_out;
    logic [7:0] b_out;
    logic [1:0] power_use;
    logic [2:0] state;
    logic       fault;

    modport master (
        output on_req, tgt_in, tgt_dec, power_level,
        output r_in, g_in, b_in,
        input  len_in, len_dec, r_out, g_out, b_out,
        input  power_use, state, fault
    );

    modport slave (
        input  on_req, tgt_in, tgt_dec, power_level,
        input  r_in, g_in, b_in,
        output len_in, len_dec, r_out, g_out, b_out,
        output power_use, state, fault
    );

endinterface

// File: rtl/lightsaber_sequencer_ramp_divider.sv
// Ramp tick generator: one tick every DIV cycles since the last clear.
module ramp_divider #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = (cnt_q == 8'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lightsaber_sequencer.sv
// Blade ignition/retraction sequencer with low-power fault handling.
module lightsaber_sequencer
    import lightsaber_pkg::*;
#(
    parameter int unsigned RAMP_DIV   = RAMP_DIV_DEF,
    parameter int unsigned STEP       = STEP_DEF,
    parameter int unsigned LOW_THRESH = LOW_THRESH_DEF
) (
    input logic                  clk,
    input logic                  rst,
    lightsaber_sequencer_if.slave bus
);

    state_e     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic       fault_q, fault_d;
    rgb_t       col_q, col_d;
    rgb_t       out_q, out_d;
    logic [1:0] pwr_q, pwr_d;
    logic [7:0] tgt;
    logic [8:0] up;
    logic       pwr_ok;
    logic       ramping;
    logic       clr;
    logic       tick;
    logic       latch;

    assign tgt     = {bus.tgt_in, bus.tgt_dec};
    assign pwr_ok  = (bus.power_level >= 8'(LOW_THRESH));
    assign up      = {1'b0, len_q} + 9'(STEP);
    assign ramping = (state_q == S_IGNITING) || (state_q == S_RETRACTING);
    // Divider restarts on every state change so the first tick lands RAMP_DIV cycles in.
    assign clr     = (state_d != state_q) || !ramping;

    ramp_divider #(.DIV(RAMP_DIV)) u_div (
        .clk   (clk),
        .rst   (rst),
        .clear (clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        fault_d = fault_q;
        latch   = 1'b0;
        unique case (state_q)
            S_OFF: begin
                if (bus.on_req && !fault_q && pwr_ok) begin
                    state_d = S_IGNITING;
                    latch   = 1'b1;
                end else if (!bus.on_req) begin
                    fault_d = 1'b0;
                end
            end
            S_IGNITING: begin
                if (!pwr_ok) begin
                    fault_d = 1'b1;
                    state_d = S_RETRACTING;
                end else if (!bus.on_req) begin
                    state_d = S_RETRACTING;
                end else if (len_q == tgt) begin
                    state_d = S_ON;
                end else if (tick) begin
                    len_d = (up > {1'b0, tgt}) ? tgt : up[7:0];
                end
            end
            S_ON: begin
                if (!pwr_ok) begin
                    fault_d = 1'b1;
                    state_d = S_RETRACTING;
                end else if (!bus.on_req) begin
                    state_d = S_RETRACTING;
                end else if (tgt > len_q) begin
                    state_d = S_IGNITING;
                end else if (tgt < len_q) begin
                    state_d = S_RETRACTING;
                end
            end
            S_RETRACTING: begin
                if (bus.on_req && !fault_q && pwr_ok) begin
                    state_d = S_IGNITING;
                    latch   = 1'b1;
                end else if (len_q == 8'd0) begin
                    state_d = S_OFF;
                end else if (tick) begin
                    len_d = (len_q > 8'(STEP)) ? len_q - 8'(STEP) : 8'd0;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    always_comb begin
        col_d = col_q;
        if (latch) begin
            col_d = '{r: bus.r_in, g: bus.g_in, b: bus.b_in};
        end
        out_d = (len_d != 8'd0) ? col_d : '0;
        pwr_d = PWR_OFF;
        unique case (state_d)
            S_IGNITING, S_RETRACTING: pwr_d = PWR_RAMP;
            S_ON:                     pwr_d = PWR_HOLD;
            default:                  pwr_d = PWR_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            len_q   <= '0;
            fault_q <= 1'b0;
            col_q   <= '0;
            out_q   <= '0;
            pwr_q   <= PWR_OFF;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            fault_q <= fault_d;
            col_q   <= col_d;
            out_q   <= out_d;
            pwr_q   <= pwr_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.len_in    = len_q[7:6];
    assign bus.len_dec   = len_q[5:0];
    assign bus.fault     = fault_q;
    assign bus.power_use = pwr_q;
    assign bus.r_out     = out_q.r;
    assign bus.g_out     = out_q.g;
    assign bus.b_out     = out_q.b;

endmodule

// File: tb/tb_lightsaber_sequencer.sv
// Directed vector bench for lightsaber_sequencer at default parameters.
module tb_lightsaber_sequencer;

    typedef struct {
        logic       on;
        logic [7:0] tgt;
        logic [7:0] pwr;
        logic [7:0] r, g, b;
        int         n;
        int         st;
        int         len;
        int         flt;
        int         pu;
        int         ro, go, bo;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lightsaber_sequencer_if ifc ();

    lightsaber_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int len,
                             input int flt, input int pu,
                             input int ro, input int go, input int bo);
        check({tag, ".state"}, int'(ifc.state), st);
        check({tag, ".len"}, int'({ifc.len_in, ifc.len_dec}), len);
        check({tag, ".fault"}, int'(ifc.fault), flt);
        check({tag, ".power_use"}, int'(ifc.power_use), pu);
        check({tag, ".r_out"}, int'(ifc.r_out), ro);
        check({tag, ".g_out"}, int'(ifc.g_out), go);
        check({tag, ".b_out"}, int'(ifc.b_out), bo);
    endtask

    task automatic drive(input logic on, input logic [7:0] tgt,
                         input logic [7:0] pwr, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
        ifc.on_req      = on;
        ifc.tgt_in      = tgt[7:6];
        ifc.tgt_dec     = tgt[5:0];
        ifc.power_level = pwr;
        ifc.r_in        = r;
        ifc.g_in        = g;
        ifc.b_in        = b;
    endtask

    function automatic vec_t mk(input logic on, input logic [7:0] tgt,
                                input logic [7:0] pwr, input logic [7:0] c,
                                input int n, input int st, input int len,
                                input int flt, input int pu, input int co);
        vec_t v;
        v.on  = on;  v.tgt = tgt; v.pwr = pwr;
        v.r   = c;   v.g   = c;   v.b   = c;
        v.n   = n;   v.st  = st;  v.len = len;
        v.flt = flt; v.pu  = pu;
        v.ro  = co;  v.go  = co;  v.bo  = co;
        return v;
    endfunction

    vec_t vt[22];

    initial begin
        // Continuous run: ignite, hold, retract, zero target, retarget, fault.
        vt[0]  = mk(1, 114, 200, 255,   1, 1,   0, 0, 2,   0);
        vt[1]  = mk(1, 114, 200, 255,   4, 1,   4, 0, 2, 255);
        vt[2]  = mk(1, 114, 200, 255, 112, 1, 114, 0, 2, 255);
        vt[3]  = mk(1, 114, 200, 255,   1, 2, 114, 0, 1, 255);
        vt[4]  = mk(0, 114, 200, 255,   1, 3, 114, 0, 2, 255);
        vt[5]  = mk(0, 114, 200, 255,   4, 3, 110, 0, 2, 255);
        vt[6]  = mk(0, 114, 200, 255, 112, 3,   0, 0, 2,   0);
        vt[7]  = mk(0, 114, 200, 255,   1, 0,   0, 0, 0,   0);
        vt[8]  = mk(1,   0, 200, 255,   1, 1,   0, 0, 2,   0);
        vt[9]  = mk(1,   0, 200, 255,   1, 2,   0, 0, 1,   0);
        vt[10] = mk(0,   0, 200, 255,   1, 3,   0, 0, 2,   0);
        vt[11] = mk(0,   0, 200, 255,   1, 0,   0, 0, 0,   0);
        vt[12] = mk(1, 114, 200, 255, 118, 2, 114, 0, 1, 255);
        vt[13] = mk(1, 161, 200, 255,   1, 1, 114, 0, 2, 255);
        vt[14] = mk(1, 161, 200, 255,  48, 1, 161, 0, 2, 255);
        vt[15] = mk(1, 161, 200, 255,   1, 2, 161, 0, 1, 255);
        vt[16] = mk(1, 161,   7, 255,   1, 3, 161, 1, 2, 255);
        vt[17] = mk(1, 161,   7, 255, 164, 3,   0, 1, 2,   0);
        vt[18] = mk(1, 161,   7, 255,   1, 0,   0, 1, 0,   0);
        vt[19] = mk(1, 161, 200, 255,   3, 0,   0, 1, 0,   0);
        vt[20] = mk(0, 161, 200, 255,   1, 0,   0, 0, 0,   0);
        vt[21] = mk(1, 161, 200, 255,   1, 1,   0, 0, 2,   0);

        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step(2);
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].on, vt[i].tgt, vt[i].pwr, vt[i].r, vt[i].g, vt[i].b);
            step(vt[i].n);
            check_all($sformatf("v%0d", i), vt[i].st, vt[i].len, vt[i].flt,
                      vt[i].pu, vt[i].ro, vt[i].go, vt[i].bo);
        end

        // Reversal mid-ramp, then reset mid-ramp.
        drive(0, 114, 200, 255, 255, 255);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_all("rev.rst", 0, 0, 0, 0, 0, 0, 0);
        drive(1, 114, 200, 255, 255, 255);
        step(41);
        check_all("rev.up40", 1, 40, 0, 2, 255, 255, 255);
        drive(0, 114, 200, 255, 255, 255);
        step(1);
        check_all("rev.drop", 3, 40, 0, 2, 255, 255, 255);
        step(20);
        check_all("rev.dn20", 3, 20, 0, 2, 255, 255, 255);
        drive(1, 114, 200, 128, 0, 128);
        step(1);
        check_all("rev.rise", 1, 20, 0, 2, 128, 0, 128);
        step(4);
        check_all("rev.up24", 1, 24, 0, 2, 128, 0, 128);
        step(36);
        check_all("mid.up60", 1, 60, 0, 2, 128, 0, 128);
        rst = 1'b1;
        step(1);
        check_all("mid.rst", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1);
        check_all("mid.reig", 1, 0, 0, 2, 0, 0, 0);
        step(4);
        check_all("mid.up4", 1, 4, 0, 2, 128, 0, 128);

        // Ignition blocked while power is below threshold.
        drive(0, 114, 3, 10, 20, 30);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        drive(1, 114, 3, 10, 20, 30);
        step(3);
        check_all("lowpwr", 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
